// File: rtl/rv_32i_pkg.sv
// Shared RV32I/RV64I constants for the memory stage: opcodes, funct3 encodings,
// FSM state type and the funct3 legality rule.
package rv_32i_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    // Doubleword and unsigned-word accesses exist only on a 64-bit datapath.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3, input int xlen);
        logic ok;
        ok = 1'b0;
        if (is_load) begin
            case (f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                F3_D, F3_WU:                    ok = (xlen == 64);
                default:                        ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_B, F3_H, F3_W: ok = 1'b1;
                F3_D:             ok = (xlen == 64);
                default:          ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_unit_load_align.sv
// Selects the addressed lane of a load response and sign/zero extends it
// to the full register width according to funct3.
module load_align
    import rv_32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  data_out
);

    logic [XLEN-1:0] lane;
    logic            sgn;
    int              nbits;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    sgn = lane[7];
            F3_H:    sgn = lane[15];
            F3_W:    sgn = lane[31];
            default: sgn = 1'b0;
        endcase
        nbits = 8 << funct3[1:0];
        data_out = '0;
        for (int i = 0; i < XLEN; i++) begin
            data_out[i] = (i < nbits) ? lane[i] : sgn;
        end
    end

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage: passes ALU results through, issues aligned load/store requests,
// waits for the response with a bounded timeout and reports faults.
//
// state   | meaning
// IDLE    | ready for a new instruction; non-memory and faulting ops complete here
// REQ     | mem_req held with stable attributes until mem_gnt
// WAIT    | granted, counting cycles until mem_rvalid or TIMEOUT
module mem_stage_unit
    import rv_32i_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode_in,
    input  logic [2:0]        funct3_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [XLEN-1:0]   store_data_in,
    input  logic [XLEN-1:0]   rd_data_in,
    input  logic [4:0]        rd_addr_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    output logic [XLEN-1:0]   rd_data_out,
    output logic [4:0]        rd_addr_out,
    output logic [6:0]        opcode_out,
    output logic [2:0]        funct3_out,
    output logic              fault_out,
    output logic              timeout_out
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t       state, state_nxt;
    logic             accept, is_load, is_store, is_mem, legal, misaligned, mem_fault;
    logic [2:0]       size_mask;
    logic [7:0]       be_base;
    logic [BE_W-1:0]  be_calc, be_q;
    logic [XLEN-1:0]  wdata_calc, load_data;
    logic [OFF_W-1:0] off_q;
    logic             we_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             got_rsp, timed_out;

    assign accept   = in_valid && in_ready;
    assign is_load  = (opcode_in == OP_LOAD);
    assign is_store = (opcode_in == OP_STORE);
    assign is_mem   = is_load || is_store;
    assign legal    = f3_legal(is_load, funct3_in, XLEN);

    always_comb begin
        case (funct3_in[1:0])
            2'd0:    begin size_mask = 3'b000; be_base = 8'h01; end
            2'd1:    begin size_mask = 3'b001; be_base = 8'h03; end
            2'd2:    begin size_mask = 3'b011; be_base = 8'h0F; end
            default: begin size_mask = 3'b111; be_base = 8'hFF; end
        endcase
        case (funct3_in[1:0])
            2'd0:    wdata_calc = {(XLEN/8){store_data_in[7:0]}};
            2'd1:    wdata_calc = {(XLEN/16){store_data_in[15:0]}};
            2'd2:    wdata_calc = {(XLEN/32){store_data_in[31:0]}};
            default: wdata_calc = store_data_in;
        endcase
        be_calc = BE_W'(be_base) << addr_in[OFF_W-1:0];
    end

    assign misaligned = |(addr_in[2:0] & size_mask);
    assign mem_fault  = !legal || misaligned;

    // A grant that arrives together with the response skips WAIT entirely.
    assign got_rsp   = ((state == ST_REQ) && mem_gnt && mem_rvalid) ||
                       ((state == ST_WAIT) && mem_rvalid);
    assign timed_out = (state == ST_WAIT) && !mem_rvalid &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && is_mem && !mem_fault) state_nxt = ST_REQ;
            ST_REQ:  if (mem_gnt) state_nxt = mem_rvalid ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (mem_rvalid || timed_out) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE) && !halt && rst_n;
        mem_req  = (state == ST_REQ);
        mem_we   = mem_req && we_q;
        mem_be   = mem_req ? be_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state != ST_WAIT) wait_cnt <= '0;
        else                            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_load_align (
        .rdata    (mem_rdata),
        .offset   (off_q),
        .funct3   (funct3_out),
        .data_out (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            rd_data_out <= '0;
            rd_addr_out <= '0;
            opcode_out  <= '0;
            funct3_out  <= '0;
            fault_out   <= 1'b0;
            timeout_out <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            be_q        <= '0;
            off_q       <= '0;
            we_q        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                opcode_out  <= opcode_in;
                funct3_out  <= funct3_in;
                rd_addr_out <= rd_addr_in;
                mem_addr    <= {addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                mem_wdata   <= wdata_calc;
                be_q        <= be_calc;
                off_q       <= addr_in[OFF_W-1:0];
                we_q        <= is_store;
                if (!is_mem) begin
                    out_valid   <= 1'b1;
                    rd_data_out <= rd_data_in;
                    fault_out   <= 1'b0;
                    timeout_out <= 1'b0;
                end else if (mem_fault) begin
                    out_valid   <= 1'b1;
                    rd_data_out <= '0;
                    fault_out   <= 1'b1;
                    timeout_out <= 1'b0;
                end
            end
            if (got_rsp) begin
                out_valid   <= 1'b1;
                rd_data_out <= we_q ? '0 : load_data;
                fault_out   <= 1'b0;
                timeout_out <= 1'b0;
            end
            if (timed_out) begin
                out_valid   <= 1'b1;
                rd_data_out <= '0;
                fault_out   <= 1'b0;
                timeout_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: directed cases plus randomized traffic
// checked against an arithmetic reference model of the memory stage.
module tb_mem_stage_unit;
    import rv_32i_pkg::*;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 15;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    logic              clk, rst_n, halt, in_valid, in_ready;
    logic [6:0]        opcode_in;
    logic [2:0]        funct3_in;
    logic [ADDR_W-1:0] addr_in;
    logic [XLEN-1:0]   store_data_in, rd_data_in;
    logic [4:0]        rd_addr_in;
    logic              mem_req, mem_we;
    logic [XLEN/8-1:0] mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_gnt, mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              out_valid;
    logic [XLEN-1:0]   rd_data_out;
    logic [4:0]        rd_addr_out;
    logic [6:0]        opcode_out;
    logic [2:0]        funct3_out;
    logic              fault_out, timeout_out;

    mem_stage_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .in_valid(in_valid), .in_ready(in_ready),
        .opcode_in(opcode_in), .funct3_in(funct3_in), .addr_in(addr_in),
        .store_data_in(store_data_in), .rd_data_in(rd_data_in), .rd_addr_in(rd_addr_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .rd_data_out(rd_data_out), .rd_addr_out(rd_addr_out),
        .opcode_out(opcode_out), .funct3_out(funct3_out), .fault_out(fault_out),
        .timeout_out(timeout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        fault;
        logic        tmo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic mem_req_exp = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: sizes, alignment and extension from plain arithmetic.
    function automatic bit ref_legal(input bit is_load, input int f3);
        if (is_load) return f3 inside {0, 1, 2, 4, 5};
        return f3 inside {0, 1, 2};
    endfunction

    function automatic int ref_size(input int f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr, input int f3);
        longint unsigned lane;
        longint          val;
        int              bits;
        bits = 8 * ref_size(f3);
        lane = 64'(rdata) >> (8 * (addr % 4));
        lane = lane % (64'd1 << bits);
        val  = longint'(lane);
        if (f3 < 4 && lane >= (64'd1 << (bits - 1))) val = val - (longint'(1) << bits);
        return val[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] addr, input int f3);
        logic [3:0] be;
        be = '0;
        for (int k = 0; k < ref_size(f3); k++) be = be | 4'(1 << ((addr % 4) + k));
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] sdata, input int f3);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = sdata[8*(b % ref_size(f3)) +: 8];
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mem_req", mem_req, mem_req_exp);
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else if (out_valid) begin
                mon_e = exp_q.pop_front();
                chk("latency_cycle", cyc, mon_e.cyc);
                chk("rd_data_out", rd_data_out, mon_e.data);
                chk("rd_addr_out", rd_addr_out, mon_e.rd);
                chk("opcode_out", opcode_out, mon_e.op);
                chk("funct3_out", funct3_out, mon_e.f3);
                chk("fault_out", fault_out, mon_e.fault);
                chk("timeout_out", timeout_out, mon_e.tmo);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // rdly < 0: response with the grant; rdly >= TIMEOUT: no response at all.
    task automatic do_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] alu, input logic [4:0] rd,
                          input int gdly, input int rdly, input logic [31:0] rdata, input bit halt_mid);
        exp_t e;
        int   a;
        bit   is_ld, is_st, flt;
        is_ld = (op == OP_LOAD);
        is_st = (op == OP_STORE);
        flt   = (is_ld || is_st) && (!ref_legal(is_ld, int'(f3)) || (addr % ref_size(int'(f3))) != 0);
        @(negedge clk);
        opcode_in = op; funct3_in = f3; addr_in = addr; store_data_in = sdata;
        rd_data_in = alu; rd_addr_in = rd; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = cyc;
        e.rd = rd; e.op = op; e.f3 = f3; e.fault = 1'b0; e.tmo = 1'b0; e.data = '0; e.cyc = a;
        if (!(is_ld || is_st)) begin
            e.data = alu;
            exp_q.push_back(e);
        end else if (flt) begin
            e.fault = 1'b1;
            exp_q.push_back(e);
        end else begin
            if (rdly >= TIMEOUT) begin
                e.tmo = 1'b1;
                e.cyc = a + gdly + 1 + TIMEOUT;
            end else begin
                e.data = is_ld ? ref_load(rdata, addr, int'(f3)) : 32'h0;
                e.cyc  = (rdly < 0) ? a + gdly + 1 : a + gdly + rdly + 2;
            end
            exp_q.push_back(e);
            mem_req_exp = 1'b1;
            halt = halt_mid;
            for (int i = 0; i <= gdly; i++) begin
                @(negedge clk);
                chk("mem_addr", mem_addr, addr - (addr % 4));
                chk("mem_we", mem_we, is_st);
                if (is_st) begin
                    chk("mem_be", mem_be, ref_be(addr, int'(f3)));
                    chk("mem_wdata", mem_wdata, ref_wdata(sdata, int'(f3)));
                end
            end
            mem_gnt = 1'b1;
            if (rdly < 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_req_exp = 1'b0;
            if (rdly >= 0 && rdly < TIMEOUT) begin
                repeat (rdly) @(negedge clk);
                @(negedge clk);
                mem_rvalid = 1'b1; mem_rdata = rdata;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
        end
        drain();
        if (e.tmo) begin
            @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            repeat (2) @(negedge clk);
        end
        halt = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, rdly;
        logic [6:0] op;
        rst_n = 1'b0; halt = 1'b0; in_valid = 1'b0; opcode_in = '0; funct3_in = '0;
        addr_in = '0; store_data_in = '0; rd_data_in = '0; rd_addr_in = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_be", mem_be, 0);
        chk("reset_rd_data", rd_data_out, 0);
        chk("reset_fault", fault_out, 0);
        chk("reset_timeout", timeout_out, 0);
        rst_n = 1'b1;

        do_txn(OP_ADD, 3'd0, 32'h0, 32'h0, 32'h1234, 5'd5, 0, 0, 32'h0, 1'b0);
        do_txn(OP_LOAD, F3_B, 32'h103, 32'h0, 32'h0, 5'd6, 0, -1, 32'h80FF_FF7F, 1'b0);
        do_txn(OP_STORE, F3_H, 32'h102, 32'hAAAA_BEEF, 32'h0, 5'd7, 0, 0, 32'h0, 1'b0);
        do_txn(OP_LOAD, F3_W, 32'h101, 32'h0, 32'h0, 5'd8, 0, 0, 32'h0, 1'b0);
        do_txn(OP_LOAD, F3_W, 32'h200, 32'h0, 32'h0, 5'd9, 3, TIMEOUT, 32'h0, 1'b0);
        do_txn(OP_LOAD, F3_D, 32'h200, 32'h0, 32'h0, 5'd10, 0, 0, 32'h0, 1'b0);
        do_txn(OP_STORE, F3_BU, 32'h200, 32'h0, 32'h0, 5'd11, 0, 0, 32'h0, 1'b0);

        // Reset while waiting for a response: the transaction must vanish.
        @(negedge clk);
        opcode_in = OP_LOAD; funct3_in = F3_W; addr_in = 32'h300; rd_addr_in = 5'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_req_exp = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_req_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_mem_req", mem_req, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        chk("post_reset_out_valid", out_valid, 0);
        do_txn(OP_ADDI, 3'd0, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd13, 0, 0, 32'h0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                halt = 1'b1; opcode_in = OP_ADD; in_valid = 1'b1;
                @(negedge clk);
                chk("halt_blocks_ready", in_ready, 0);
                @(negedge clk);
                in_valid = 1'b0; halt = 1'b0;
            end
            r = $urandom_range(0, 9);
            op = (r < 3) ? ((r == 0) ? OP_ADDI : OP_ADD) : ((r < 7) ? OP_LOAD : OP_STORE);
            r = $urandom_range(0, 9);
            rdly = (r == 0) ? -1 : ((r == 9) ? TIMEOUT : $urandom_range(0, 4));
            do_txn(op, 3'($urandom_range(0, 7)), 32'h1000 + $urandom_range(0, 63), $urandom, $urandom,
                   5'($urandom_range(0, 31)), $urandom_range(0, 3), rdly, $urandom,
                   1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
